// File: rtl/pipeline_if.sv
// Handshake bundle between the pipeline sequencer and the fetch/stage/hazard logic around it.
// master = sequencer side, slave = datapath/environment side.
interface pipeline_if #(
    parameter int STAGES = 5,
    parameter int XLEN   = 32,
    parameter int CW     = 6
);
    logic              fetch_req;
    logic [XLEN-1:0]   fetch_pc;
    logic              fetch_ready;
    logic              load_use;
    logic              branch_taken;
    logic [XLEN-1:0]   branch_target;
    logic              mc_start;
    logic [CW-1:0]     mc_cycles;
    logic              dmem_wait;
    logic              halt;
    logic [STAGES-1:0] stage_en;
    logic [STAGES-1:0] stage_valid;
    logic              mc_busy;
    logic              halted;
    logic [63:0]       retired;

    modport master (
        output fetch_req, fetch_pc, stage_en, stage_valid, mc_busy, halted, retired,
        input  fetch_ready, load_use, branch_taken, branch_target, mc_start, mc_cycles,
               dmem_wait, halt
    );

    modport slave (
        input  fetch_req, fetch_pc, stage_en, stage_valid, mc_busy, halted, retired,
        output fetch_ready, load_use, branch_taken, branch_target, mc_start, mc_cycles,
               dmem_wait, halt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: owns the PC, per-stage valid bits and stage enables, and resolves
// stall/flush/bubble/multicycle/halt interactions for an in-order core of STAGES stages.
module pipeline_ctrl #(
    parameter int              STAGES   = 5,
    parameter int              XLEN     = 32,
    parameter int              MC_MAX   = 34,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic     clk,
    input  logic     resetn,
    pipeline_if.master bus
);
    localparam int CW = $clog2(MC_MAX + 1);

    typedef enum logic [1:0] {RUN, MC_WAIT, DRAIN, HALTED} state_t;

    state_t            state_reg;
    logic [STAGES-1:0] valid_reg;
    logic [STAGES-1:0] valid_next;
    logic [STAGES-1:0] en;
    logic [XLEN-1:0]   pc_reg;
    logic [CW-1:0]     cnt_reg;
    logic              mc_active_reg;
    logic [63:0]       retired_reg;

    logic              fetching;
    logic              mc_hold;
    logic              redirect;
    logic              lu_stall;
    logic              mc_go;
    logic              mc_done;
    logic              mc_active_next;
    logic              fetch_take;
    logic [CW-1:0]     mc_load;

    assign fetching = (state_reg == RUN) || (state_reg == MC_WAIT);
    assign mc_hold  = mc_active_reg && (cnt_reg != '0);
    // A redirect only acts once execute is actually advancing.
    assign redirect = bus.branch_taken && valid_reg[2] && !bus.dmem_wait && !mc_hold;
    assign lu_stall = bus.load_use && valid_reg[1] && !bus.dmem_wait && !mc_hold && !redirect;
    assign mc_go    = bus.mc_start && valid_reg[2] && !bus.dmem_wait && !mc_active_reg
                      && (state_reg != HALTED);
    assign mc_done  = mc_active_reg && (cnt_reg == '0) && !bus.dmem_wait;
    assign mc_active_next = mc_go || (mc_active_reg && !mc_done);
    assign mc_load  = (bus.mc_cycles == '0) ? '0 : bus.mc_cycles - CW'(1);
    assign fetch_take = en[0] && fetching && bus.fetch_ready && !redirect;

    // A stage whose upstream neighbour is frozen while it advances receives a bubble.
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi <= 1) begin : g_front
                assign en[gi] = !bus.dmem_wait && !mc_hold && !lu_stall;
            end else if (gi == 2) begin : g_exec
                assign en[gi] = !bus.dmem_wait && !mc_hold;
            end else begin : g_tail
                assign en[gi] = !bus.dmem_wait;
            end

            if (gi == 0) begin : g_v0
                assign valid_next[gi] = en[gi] ? fetch_take : valid_reg[gi];
            end else if (gi <= 2) begin : g_vflush
                assign valid_next[gi] = en[gi] ? (en[gi-1] && valid_reg[gi-1] && !redirect)
                                               : valid_reg[gi];
            end else begin : g_vtail
                assign valid_next[gi] = en[gi] ? (en[gi-1] && valid_reg[gi-1]) : valid_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= RUN;
            valid_reg     <= '0;
            pc_reg        <= RESET_PC;
            cnt_reg       <= '0;
            mc_active_reg <= 1'b0;
            retired_reg   <= '0;
        end else begin
            valid_reg <= valid_next;

            if (redirect)
                pc_reg <= bus.branch_target;
            else if (fetch_take)
                pc_reg <= pc_reg + XLEN'(4);

            if (valid_reg[STAGES-1] && en[STAGES-1])
                retired_reg <= retired_reg + 64'd1;

            if (mc_go) begin
                mc_active_reg <= 1'b1;
                cnt_reg       <= mc_load;
            end else if (mc_done) begin
                mc_active_reg <= 1'b0;
            end else if (mc_active_reg && !bus.dmem_wait) begin
                cnt_reg <= cnt_reg - CW'(1);
            end

            // HALTED is entered on the same edge the pipe empties, so halted tracks stage_valid==0.
            case (state_reg)
                RUN:     if (bus.halt) state_reg <= DRAIN;
                         else if (mc_go) state_reg <= MC_WAIT;
                MC_WAIT: if (bus.halt) state_reg <= DRAIN;
                         else if (mc_done) state_reg <= RUN;
                DRAIN:   if ((valid_next == '0) && !mc_active_next) state_reg <= HALTED;
                default: state_reg <= HALTED;
            endcase
        end
    end

    assign bus.fetch_req   = fetching;
    assign bus.fetch_pc    = pc_reg;
    assign bus.stage_en    = resetn ? en : '0;
    assign bus.stage_valid = valid_reg;
    assign bus.mc_busy     = mc_active_reg;
    assign bus.halted      = (state_reg == HALTED);
    assign bus.retired     = retired_reg;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomised and directed bench for pipeline_ctrl, checked every cycle against an
// instruction-level model of the pipe (instruction ids moving through stage slots).
module tb_pipeline_ctrl;
    localparam int S  = 5;
    localparam int XL = 32;
    localparam int CW = 6;
    localparam logic [XL-1:0] RPC = 32'h0000_0000;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_pass;
    int   cyc;

    pipeline_if #(.STAGES(S), .XLEN(XL), .CW(CW)) bus ();

    pipeline_ctrl #(.STAGES(S), .XLEN(XL), .MC_MAX(34), .RESET_PC(RPC)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: each slot holds an instruction id, -1 = empty
    int              m_pipe [S];
    logic [XL-1:0]   m_pc;
    int              m_mc_left;
    bit              m_drain;
    bit              m_halted;
    longint unsigned m_retired;
    int              m_seq;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        for (int s = 0; s < S; s++) m_pipe[s] = -1;
        m_pc      = RPC;
        m_mc_left = 0;
        m_drain   = 0;
        m_halted  = 0;
        m_retired = 0;
    endtask

    task automatic clear_inputs();
        bus.fetch_ready   = 1'b0;
        bus.load_use      = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        bus.mc_start      = 1'b0;
        bus.mc_cycles     = '0;
        bus.dmem_wait     = 1'b0;
        bus.halt          = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_pc"},      64'(bus.fetch_pc),    64'(RPC));
        check_eq({tag, "_valid"},   64'(bus.stage_valid), 64'd0);
        check_eq({tag, "_en"},      64'(bus.stage_en),    64'd0);
        check_eq({tag, "_mcbusy"},  64'(bus.mc_busy),     64'd0);
        check_eq({tag, "_halted"},  64'(bus.halted),      64'd0);
        check_eq({tag, "_retired"}, bus.retired,          64'd0);
    endtask

    // Compare DUT against model for the current inputs, then advance the model one cycle.
    task automatic model_step();
        int hold;
        bit redir;
        bit fetching;
        bit empty;
        int np [S];
        logic [S-1:0] exp_en;
        logic [S-1:0] exp_valid;

        hold = -1;
        if (bus.dmem_wait) hold = S - 1;
        else if (m_mc_left > 1) hold = 2;
        redir = bus.branch_taken && (m_pipe[2] >= 0) && (hold < 2);
        if ((hold < 1) && bus.load_use && (m_pipe[1] >= 0) && !redir) hold = 1;
        fetching = !m_drain && !m_halted;

        for (int s = 0; s < S; s++) begin
            exp_en[s]    = (s > hold);
            exp_valid[s] = (m_pipe[s] >= 0);
        end
        check_eq("stage_en",    64'(bus.stage_en),    64'(exp_en));
        check_eq("stage_valid", 64'(bus.stage_valid), 64'(exp_valid));
        check_eq("fetch_pc",    64'(bus.fetch_pc),    64'(m_pc));
        check_eq("fetch_req",   64'(bus.fetch_req),   64'(fetching));
        check_eq("mc_busy",     64'(bus.mc_busy),     64'(m_mc_left > 0));
        check_eq("halted",      64'(bus.halted),      64'(m_halted));
        check_eq("retired",     bus.retired,          m_retired);

        if ((hold < S - 1) && (m_pipe[S-1] >= 0)) m_retired++;

        for (int s = 0; s < S; s++) np[s] = m_pipe[s];
        for (int s = S - 1; s > hold; s--) begin
            if (s == 0) begin
                if (fetching && bus.fetch_ready && !redir) begin
                    np[0] = m_seq;
                    m_seq++;
                end else begin
                    np[0] = -1;
                end
            end else if (s == hold + 1) begin
                np[s] = -1;
            end else begin
                np[s] = m_pipe[s-1];
            end
        end
        if (redir) begin
            np[1] = -1;
            np[2] = -1;
        end

        if (bus.mc_start && (m_pipe[2] >= 0) && !bus.dmem_wait && (m_mc_left == 0) && !m_halted)
            m_mc_left = (bus.mc_cycles == 0) ? 1 : int'(bus.mc_cycles);
        else if ((m_mc_left > 0) && !bus.dmem_wait)
            m_mc_left--;

        if (redir) m_pc = bus.branch_target;
        else if ((hold < 0) && fetching && bus.fetch_ready) m_pc = m_pc + 32'd4;

        empty = 1;
        for (int s = 0; s < S; s++) if (np[s] >= 0) empty = 0;
        if (m_drain) begin
            if (empty && (m_mc_left == 0)) begin
                m_drain  = 0;
                m_halted = 1;
            end
        end else if (!m_halted && bus.halt) begin
            m_drain = 1;
        end

        for (int s = 0; s < S; s++) m_pipe[s] = np[s];
    endtask

    // Called at a negedge with inputs already set; returns at the next negedge.
    task automatic tick();
        #1;
        model_step();
        $display("cyc %0d en=%b valid=%b pc=%h mc=%0b halted=%0b retired=%0d",
                 cyc, bus.stage_en, bus.stage_valid, bus.fetch_pc, bus.mc_busy,
                 bus.halted, bus.retired);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        #1;
        check_reset_values("reset");
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        logic [XL-1:0] pc_hold;
        logic [63:0]   ret_hold;
        int            busy_cnt;
        int            frz_cnt;
        int            guard;

        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        m_seq    = 0;

        // Test 1: free-running fetch
        do_reset();
        bus.fetch_ready = 1'b1;
        repeat (10) tick();
        #1;
        check_eq("t1_pc_0x28", 64'(bus.fetch_pc), 64'(RPC + 32'h28));

        // Test 2: one-cycle load_use bubble
        pc_hold = bus.fetch_pc;
        bus.load_use = 1'b1;
        tick();
        bus.load_use = 1'b0;
        #1;
        check_eq("t2_pc_held", 64'(bus.fetch_pc), 64'(pc_hold));
        check_eq("t2_bubble_s2", 64'(bus.stage_valid[2]), 64'd0);
        repeat (3) tick();

        // Test 3: branch overrides load_use
        bus.branch_taken  = 1'b1;
        bus.load_use      = 1'b1;
        bus.branch_target = 32'h0000_0100;
        tick();
        bus.branch_taken = 1'b0;
        bus.load_use     = 1'b0;
        #1;
        check_eq("t3_pc_target", 64'(bus.fetch_pc), 64'h100);
        check_eq("t3_flush01", 64'(bus.stage_valid[1:0]), 64'd0);
        repeat (4) tick();

        // Test 4: mc op of 4 cycles, then of 0 cycles
        bus.mc_start  = 1'b1;
        bus.mc_cycles = 6'd4;
        tick();
        bus.mc_start = 1'b0;
        busy_cnt = 0;
        frz_cnt  = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (bus.mc_busy) busy_cnt++;
            if (!bus.stage_en[0]) frz_cnt++;
            tick();
        end
        check_eq("t4_busy4", 64'(busy_cnt), 64'd4);
        check_eq("t4_freeze3", 64'(frz_cnt), 64'd3);

        bus.mc_start  = 1'b1;
        bus.mc_cycles = 6'd0;
        tick();
        bus.mc_start = 1'b0;
        busy_cnt = 0;
        frz_cnt  = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (bus.mc_busy) busy_cnt++;
            if (!bus.stage_en[0]) frz_cnt++;
            tick();
        end
        check_eq("t4_mc0_busy1", 64'(busy_cnt), 64'd1);
        check_eq("t4_mc0_nofreeze", 64'(frz_cnt), 64'd0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            bus.fetch_ready   = ($urandom_range(0, 99) < 80);
            bus.load_use      = ($urandom_range(0, 99) < 15);
            bus.branch_taken  = ($urandom_range(0, 99) < 8);
            bus.branch_target = $urandom() & 32'hFFFF_FFFC;
            bus.mc_start      = ($urandom_range(0, 99) < 8);
            bus.mc_cycles     = CW'($urandom_range(0, 8));
            bus.dmem_wait     = ($urandom_range(0, 99) < 10);
            tick();
        end
        clear_inputs();
        bus.fetch_ready = 1'b1;
        repeat (6) tick();

        // Test 5: halt while a multicycle op is active
        bus.mc_start  = 1'b1;
        bus.mc_cycles = 6'd6;
        tick();
        bus.mc_start = 1'b0;
        bus.halt     = 1'b1;
        tick();
        guard = 0;
        while (!bus.halted && guard < 60) begin
            bus.fetch_ready = 1'($urandom_range(0, 1));
            tick();
            guard++;
        end
        check_eq("t5_halt_reached", 64'(bus.halted), 64'd1);
        ret_hold = bus.retired;
        repeat (5) tick();
        check_eq("t5_retired_stable", bus.retired, ret_hold);
        check_eq("t5_fetch_req_low", 64'(bus.fetch_req), 64'd0);

        // Test 6: async reset during MC_WAIT with dmem_wait asserted
        do_reset();
        bus.fetch_ready = 1'b1;
        repeat (6) tick();
        bus.mc_start  = 1'b1;
        bus.mc_cycles = 6'd10;
        tick();
        bus.mc_start  = 1'b0;
        bus.dmem_wait = 1'b1;
        tick();
        #2;
        resetn = 1'b0;
        #1;
        check_reset_values("t6_async");
        clear_inputs();
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        bus.fetch_ready = 1'b1;
        repeat (5) tick();
        #1;
        check_eq("t6_restart_pc", 64'(bus.fetch_pc), 64'(RPC + 32'h14));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
